nv_nvdla_pdp_rdma_rsp_buf: RTL
==============================

NV_NVDLA_PDP_RDMA_RSP_BUF -- requirements
Module: nv_nvdla_pdp_rdma_rsp_buf

Interface
REQ-001 SHALL provide parameter DEPTH, default 8, response buffer entries (power of two, 2..64).
REQ-002 SHALL provide parameter RSP_PD_W, default 514, response payload width (512 data + 2 mask).
REQ-003 SHALL provide port nvdla_core_clk  input  1  clock; all state on its rising edge.
REQ-004 SHALL provide port nvdla_core_rstn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL provide port req_issue_valid  input  1  read request valid at the issuing pipe output.
REQ-006 SHALL provide port req_issue_ready  input  1  read request accepted by the DMA side.
REQ-007 SHALL provide port req_credit_ok  output  1  buffer space reserved for one more request; upstream ANDs it into its request valid.
REQ-008 SHALL provide port dma_rd_rsp_valid  input  1  DMA read response valid.
REQ-009 SHALL provide port dma_rd_rsp_ready  output  1  response accepted.
REQ-010 SHALL provide port dma_rd_rsp_pd  input  RSP_PD_W  response payload.
REQ-011 SHALL provide port rsp_valid  output  1  buffered response valid to the PDP consumer.
REQ-012 SHALL provide port rsp_ready  input  1  consumer accepts.
REQ-013 SHALL provide port rsp_pd  output  RSP_PD_W  buffered payload.
REQ-014 SHALL provide port outstanding_cnt  output  clog2(DEPTH)+1  requests issued and not yet popped.

Function
REQ-015 Issue event = req_issue_valid & req_issue_ready; pop event = rsp_valid & rsp_ready; push event = dma_rd_rsp_valid & dma_rd_rsp_ready.
REQ-016 outstanding_cnt SHALL +1 on issue only, -1 on pop only, hold on both or neither, saturating at 0 and DEPTH.
REQ-017 req_credit_ok SHALL be (outstanding_cnt < DEPTH), registered-state driven, no combinational path from any input.
REQ-018 Buffer SHALL be an in-order FIFO of DEPTH entries with wrapping read/write pointers of clog2(DEPTH)+1 bits (MSB distinguishes full from empty).
REQ-019 dma_rd_rsp_ready SHALL be !full, from registered state only.
REQ-020 Latency: payload pushed at edge N SHALL appear on rsp_valid/rsp_pd after edge N; no same-cycle bypass when empty.
REQ-021 While rsp_valid & !rsp_ready, rsp_pd SHALL hold stable.
REQ-022 Push and pop in one cycle SHALL keep occupancy unchanged; when full, a push is refused (ready=0) even if a pop occurs that cycle.
REQ-023 Occupancy SHALL never exceed outstanding_cnt when upstream honours req_credit_ok; this invariant is checked by the bench.

Reset
REQ-024 Asynchronous reset SHALL force rsp_valid=0, dma_rd_rsp_ready=1, req_credit_ok=1, outstanding_cnt=0, pointers=0.
REQ-025 Payload storage SHALL not be reset.
REQ-026 Reset mid-operation SHALL discard all buffered entries and credits; first post-reset push behaves as an empty-buffer push.

Configuration
REQ-027 Macro NVDLA_PDP_RDMA_RSP_CHK_EN SHALL add output rsp_unsolicited_err (1 bit, reset 0), set sticky when a push occurs while occupancy >= outstanding_cnt, cleared only by reset.
REQ-028 Without NVDLA_PDP_RDMA_RSP_CHK_EN, the port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-029 Reset release, idle inputs -> rsp_valid=0, dma_rd_rsp_ready=1, req_credit_ok=1, outstanding_cnt=0.
REQ-030 Issue 8 requests back-to-back with rsp_ready=0 -> outstanding_cnt reaches 8, req_credit_ok=0 at cycle after 8th issue.
REQ-031 Push payloads 0x1..0x8, rsp_ready=0 -> dma_rd_rsp_ready=0 after 8th push; then rsp_ready=1 -> 0x1..0x8 popped in order, one per cycle, outstanding_cnt returns to 0.
REQ-032 Occupancy 3, simultaneous issue, push and pop for 4 cycles -> occupancy and outstanding_cnt unchanged; output order preserved.
REQ-033 Assert reset with 5 entries buffered -> rsp_valid=0 and outstanding_cnt=0 immediately; next push 0xA5 appears on rsp_pd one cycle later.
REQ-034 With NVDLA_PDP_RDMA_RSP_CHK_EN, push with outstanding_cnt=0 -> rsp_unsolicited_err=1 and stays 1 until reset.

Source files
------------

// File: rtl/nv_nvdla_pdp_rdma_rsp_buf.sv
// PDP RDMA response buffer: credit-gated in-order FIFO between DMA read responses and PDP.
// Optional checker enabled by macro NVDLA_PDP_RDMA_RSP_CHK_EN (adds rsp_unsolicited_err).
module nv_nvdla_pdp_rdma_rsp_buf #(
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned RSP_PD_W = 514
) (
    input  logic                        nvdla_core_clk,
    input  logic                        nvdla_core_rstn,
    input  logic                        req_issue_valid,
    input  logic                        req_issue_ready,
    output logic                        req_credit_ok,
    input  logic                        dma_rd_rsp_valid,
    output logic                        dma_rd_rsp_ready,
    input  logic [RSP_PD_W-1:0]         dma_rd_rsp_pd,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [RSP_PD_W-1:0]         rsp_pd,
`ifdef NVDLA_PDP_RDMA_RSP_CHK_EN
    output logic                        rsp_unsolicited_err,
`endif
    output logic [$clog2(DEPTH):0]      outstanding_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] DepthC = CW'(DEPTH);

    logic [CW-1:0]       cnt_q, cnt_d;
    logic [CW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [RSP_PD_W-1:0] mem_q [DEPTH];

    logic issue, push, pop, full, empty;

    // Full when pointers match in index but differ in wrap bit.
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);

    assign issue = req_issue_valid & req_issue_ready;
    assign push  = dma_rd_rsp_valid & dma_rd_rsp_ready;
    assign pop   = rsp_valid & rsp_ready;

    assign req_credit_ok    = (cnt_q < DepthC);
    assign dma_rd_rsp_ready = !full;
    assign rsp_valid        = !empty;
    assign rsp_pd           = mem_q[rd_ptr_q[AW-1:0]];
    assign outstanding_cnt  = cnt_q;

    always_comb begin
        cnt_d    = cnt_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (issue && !pop && (cnt_q != DepthC)) begin
            cnt_d = cnt_q + CW'(1);
        end else if (pop && !issue && (cnt_q != '0)) begin
            cnt_d = cnt_q - CW'(1);
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + CW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + CW'(1);
        end
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Payload storage intentionally has no reset.
    always_ff @(posedge nvdla_core_clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= dma_rd_rsp_pd;
        end
    end

`ifdef NVDLA_PDP_RDMA_RSP_CHK_EN
    logic [CW-1:0] occupancy;
    logic          err_q, err_d;

    assign occupancy = wr_ptr_q - rd_ptr_q;

    // A response arriving with no unmatched request outstanding is unsolicited.
    always_comb begin
        err_d = err_q;
        if (push && (occupancy >= cnt_q)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign rsp_unsolicited_err = err_q;
`endif

endmodule
